// File: rtl/tensor_sequencer.sv
// Tensor sequencer: moves tile data between data memory and the tile
// register files, and drives the MAC engine for result write-back.
module tensor_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ELEMS  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              store_tensor,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              tile_we_a,
  output logic              tile_we_b,
  output logic [IDX_W-1:0]  tile_idx,
  output logic [DATA_W-1:0] tile_wdata,
  input  logic [DATA_W-1:0] res_data,
  output logic              mac_start,
  input  logic              mac_done,
  output logic              tensor_op_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CALC,
    S_WR_REQ,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ELEMS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               op_b_q, op_b_d;
  logic               first_q, first_d;
  logic               armed_q, armed_d;

  logic any_cmd;
  logic st_rd_req, st_rd_wait, st_calc, st_wr_req;

  assign any_cmd = load_a | load_b | store_tensor;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    op_b_d  = op_b_q;
    first_d = first_q;
    armed_d = armed_q;

    // A held command must fall before the next one is accepted
    if (state_q == S_DONE) begin
      armed_d = 1'b0;
    end else if (!any_cmd) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && any_cmd) begin
          base_d = base_addr;
          idx_d  = '0;
          op_b_d = !load_a && load_b;
          if (load_a || load_b) begin
            state_d = S_RD_REQ;
          end else begin
            state_d = S_CALC;
            first_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_CALC: begin
        first_d = 1'b0;
        if (mac_done) begin
          idx_d   = '0;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (mem_gnt) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      op_b_q  <= 1'b0;
      first_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      op_b_q  <= op_b_d;
      first_q <= first_d;
      armed_q <= armed_d;
    end
  end

  assign st_rd_req  = (state_q == S_RD_REQ);
  assign st_rd_wait = (state_q == S_RD_WAIT);
  assign st_calc    = (state_q == S_CALC);
  assign st_wr_req  = (state_q == S_WR_REQ);

  assign mem_req   = st_rd_req | st_wr_req;
  assign mem_we    = st_wr_req;
  assign mem_addr  = mem_req ?
                     base_q + {{(ADDR_W-IDX_W){1'b0}}, idx_q} : '0;
  assign mem_wdata = st_wr_req ? res_data : '0;

  assign tile_we_a  = st_rd_wait & mem_rvalid & ~op_b_q;
  assign tile_we_b  = st_rd_wait & mem_rvalid & op_b_q;
  assign tile_idx   = (st_rd_wait | st_wr_req) ? idx_q : '0;
  assign tile_wdata = mem_rdata;

  assign mac_start      = st_calc & first_q;
  assign tensor_op_done = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/tensor_sequencer.md
# tensor_sequencer

Sequencer for the tensor datapath of the 16-bit processor. While the control unit stalls in a tensor state, this block walks the data memory and moves ELEMS words into tile A or tile B, or launches the MAC engine and writes the result tile back. It then returns a one-cycle `tensor_op_done` that releases the control unit. It sits between the control unit's tensor control lines, the shared data-memory port (granted by the memory arbiter), the tile register files and the MAC engine.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, word width
- ELEMS, 4, words per tile (power of two, ≥2)
- IDX_W, 2, log2(ELEMS)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; one clock, and the reset is synchronous and active-low
- load_a  in  1  control line: load tile A (held high until done is seen)
- load_b  in  1  control line: load tile B
- store_tensor  in  1  control line: compute and store result tile
- base_addr  in  ADDR_W  tile base address, sampled at command accept
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  mem_rdata valid (≥1 cycle after gnt)
- tile_we_a  out  1  write strobe, tile A
- tile_we_b  out  1  write strobe, tile B
- tile_idx  out  IDX_W  element index for tile write / result read
- tile_wdata  out  DATA_W  tile write data (= mem_rdata)
- res_data  in  DATA_W  result element at tile_idx (combinational)
- mac_start  out  1  one-cycle MAC launch pulse
- mac_done  in  1  MAC result valid
- tensor_op_done  out  1  one-cycle completion pulse
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, DONE.
- IDLE: accept a command only when `armed`=1. Priority is load_a > load_b > store_tensor. On accept, latch the op, base register ← base_addr and idx ← 0. Loads go to RD_REQ; store goes to CALC.
- `armed`: cleared in DONE. Set in any cycle where load_a, load_b and store_tensor are all low. Reset value is 1. This prevents a held command from retriggering.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=base+idx. Moves to RD_WAIT on mem_gnt; otherwise holds with the address stable.
- RD_WAIT: on mem_rvalid, pulse tile_we_a or tile_we_b (per latched op) in that same cycle, with tile_idx=idx and tile_wdata=mem_rdata. Then if idx==ELEMS-1 → DONE, else idx+1 → RD_REQ. One read outstanding at most.
- CALC: mac_start=1 only in the first CALC cycle. Waits for mac_done, then idx ← 0 → WR_REQ. A mac_done in the first CALC cycle is honoured.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=base+idx, tile_idx=idx, mem_wdata=res_data. On mem_gnt: if idx==ELEMS-1 → DONE, else idx+1 and stay in WR_REQ.
- DONE: tensor_op_done=1 for exactly this cycle, then → IDLE.
- Addresses are base+idx modulo 2^ADDR_W; wrap at 0xFFFF→0x0000 is legal and silent.
- Command lines are ignored outside IDLE. Dropping or changing them mid-operation has no effect.
- mem_rvalid outside RD_WAIT is ignored; no tile write occurs. mac_done outside CALC is ignored.

## Timing
- Outputs are Moore-decoded from state, except tile_we_a/b (RD_WAIT & mem_rvalid).
- Reset values: state IDLE, idx 0, armed 1. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, tile_we_a/b, tile_idx, mac_start, tensor_op_done, busy.
- Reset mid-operation: IDLE on the next edge, with no done pulse and no further memory or tile strobes. A pending mem_rvalid is discarded.
- Load, zero-wait memory (gnt in RD_REQ, rvalid in the next cycle), command first seen at cycle n:
  - RD_REQ at n+1+2i and RD_WAIT at n+2+2i, for i=0..ELEMS-1.
  - DONE at n+2·ELEMS+1 (n+9 for ELEMS=4); IDLE at n+10.
- Store, mac_done k cycles after mac_start (k≥0), all writes granted immediately: WR_REQ from n+2+k for ELEMS cycles, DONE at n+2+k+ELEMS.
- Each cycle of mem_gnt low adds one cycle. Each cycle of mem_rvalid delay adds one cycle.
- The control unit leaves its stall state on the done edge, so the command line falls at n+10. `armed` is set that cycle, and a new command is accepted no earlier than n+11.

## Test plan
- Load A, base 0x0010, immediate gnt, memory returns 0xA000+addr → tile_we_a at cycles n+2,4,6,8 with idx 0..3 and data 0xA010..0xA013; tensor_op_done only at n+9; tile_we_b never asserts.
- Load B, base 0xFFFE, gnt delayed 2 cycles per request → addresses FFFE, FFFF, 0000, 0001; mem_addr stable while gnt is low; done at n+17.
- Store, base 0x0100, mac_done 3 cycles after mac_start, res_data=0xC000+idx → single mac_start at n+1; writes 0xC000..0xC003 to 0x0100..0x0103 at n+5..n+8; done at n+9.
- load_a held high 5 cycles after done → no second operation and busy stays 0. Drop it for 1 cycle, then raise load_b → load B starts.
- load_a and store_tensor both high in IDLE → load A runs. Toggling store_tensor mid-load is ignored.
- reset low during RD_WAIT, with mem_rvalid arriving in the same cycle → no tile write after the edge, all outputs 0, no done pulse; the next load_a starts at idx 0.
